// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer: host-programmable duty fader driving one pwm instance
// over its byte-bus write port (ctl0 @0x00, duty_hi @0x01, duty_lo @0x02).
// A GO write latches the target, enables the pwm, then steps the duty toward
// the target by STEP every INTV clocks without ever passing it.
module pwm_fade_sequencer #(
  parameter int PWM_BITS      = 10,
  parameter int INTERVAL_BITS = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] b_addr_i,
  input  logic [7:0] b_data_i,
  input  logic       b_write_i,
  output logic [7:0] b_data_o,
  output logic [7:0] m_addr_o,
  output logic [7:0] m_data_o,
  output logic       m_write_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_WR_LO = 3'd4;

  // One extra bit so cur+step and cur-step never wrap before clamping.
  localparam int DW = PWM_BITS + 1;

  logic [1:0]               r_ss;
  logic [PWM_BITS-1:0]      r_tgt;
  logic [7:0]               r_step;
  logic [INTERVAL_BITS-1:0] r_intv;

  logic [2:0]               r_state;
  logic [PWM_BITS-1:0]      r_act_tgt;
  logic [PWM_BITS-1:0]      r_cur;
  logic [PWM_BITS-1:0]      r_nxt;
  logic [INTERVAL_BITS-1:0] r_cnt;
  logic                     r_done;
  logic                     r_aborted;
  logic                     r_abort_pend;

  logic [7:0]               r_m_addr;
  logic [7:0]               r_m_data;
  logic                     r_m_write;

  logic                     w_wr_ctrl;
  logic                     w_go;
  logic                     w_abort;
  logic                     w_busy;
  logic [7:0]               w_step_eff;
  logic [INTERVAL_BITS-1:0] w_intv_eff;
  logic [INTERVAL_BITS-1:0] w_intv_last;

  assign w_wr_ctrl   = b_write_i && (b_addr_i == 8'h00);
  assign w_go        = w_wr_ctrl && b_data_i[7];
  assign w_abort     = w_wr_ctrl && b_data_i[6];
  assign w_busy      = (r_state != S_IDLE);
  assign w_step_eff  = (r_step == 8'd0) ? 8'd1 : r_step;
  assign w_intv_eff  = (r_intv == '0) ? INTERVAL_BITS'(1) : r_intv;
  assign w_intv_last = w_intv_eff - INTERVAL_BITS'(1);

  assign m_addr_o  = r_m_addr;
  assign m_data_o  = r_m_data;
  assign m_write_o = r_m_write;

  // Next duty: one step toward the target, clamped so it never passes it.
  function automatic logic [PWM_BITS-1:0] f_next_duty(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt,
    input logic [7:0]          step
  );
    logic [DW-1:0] c;
    logic [DW-1:0] t;
    logic [DW-1:0] s;
    logic [DW-1:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = DW'(step);
    if (t > c) begin
      r = c + s;
      if (r > t) r = t;
    end else begin
      if ((c - t) <= s) r = t;
      else              r = c - s;
    end
    return r[PWM_BITS-1:0];
  endfunction

  // Host-writable configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ss   <= '0;
      r_tgt  <= '0;
      r_step <= '0;
      r_intv <= '0;
    end else if (b_write_i) begin
      case (b_addr_i)
        8'h00: r_ss                      <= b_data_i[1:0];
        8'h01: r_tgt[PWM_BITS-1:8]       <= b_data_i[PWM_BITS-9:0];
        8'h02: r_tgt[7:0]                <= b_data_i;
        8'h03: r_step                    <= b_data_i;
        8'h04: r_intv[INTERVAL_BITS-1:8] <= b_data_i[INTERVAL_BITS-9:0];
        8'h05: r_intv[7:0]               <= b_data_i;
        default: ;
      endcase
    end
  end

  // Fade sequencer FSM; also owns the registered pwm write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_act_tgt    <= '0;
      r_cur        <= '0;
      r_nxt        <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_m_addr     <= 8'h00;
      r_m_data     <= 8'h00;
      r_m_write    <= 1'b0;
    end else begin
      r_m_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // ABORT in the same write suppresses GO.
          if (w_go && !w_abort) begin
            r_act_tgt    <= r_tgt;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_cnt        <= '0;
            r_state      <= S_INIT;
          end
        end
        S_INIT: begin
          if (w_abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_go) begin
            r_act_tgt <= r_tgt;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_INIT;
          end else begin
            r_m_write <= 1'b1;
            r_m_addr  <= 8'h00;
            r_m_data  <= {1'b1, 5'b0, r_ss};
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            r_aborted <= 1'b1;
            r_state   <= S_IDLE;
          end else if (w_go) begin
            r_act_tgt <= r_tgt;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_INIT;
          end else if (r_cur == r_act_tgt) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt >= w_intv_last) begin
            // >= keeps the counter from running away if INTV shrinks mid-count.
            r_nxt   <= f_next_duty(r_cur, r_act_tgt, w_step_eff);
            r_state <= S_WR_HI;
          end else begin
            r_cnt <= r_cnt + INTERVAL_BITS'(1);
          end
        end
        S_WR_HI: begin
          // Nothing has reached the pwm yet for this step, so GO may restart here;
          // ABORT instead lets the full duty pair go out first.
          if (w_go && !w_abort) begin
            r_act_tgt <= r_tgt;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_INIT;
          end else begin
            r_m_write <= 1'b1;
            r_m_addr  <= 8'h01;
            r_m_data  <= 8'(r_nxt[PWM_BITS-1:8]);
            if (w_abort) r_abort_pend <= 1'b1;
            r_state   <= S_WR_LO;
          end
        end
        S_WR_LO: begin
          // Always finish the low byte so duty_hi/duty_lo stay consistent.
          r_m_write <= 1'b1;
          r_m_addr  <= 8'h02;
          r_m_data  <= r_nxt[7:0];
          r_cur     <= r_nxt;
          r_cnt     <= '0;
          if (w_abort || r_abort_pend) begin
            r_aborted    <= 1'b1;
            r_abort_pend <= 1'b0;
            r_state      <= S_IDLE;
          end else if (w_go) begin
            r_act_tgt <= r_tgt;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_state   <= S_INIT;
          end else if (r_nxt == r_act_tgt) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational host read mux; unmapped addresses read as zero.
  always_comb begin
    b_data_o = 8'h00;
    case (b_addr_i)
      8'h00: b_data_o = {6'b0, r_ss};
      8'h01: b_data_o = 8'(r_tgt[PWM_BITS-1:8]);
      8'h02: b_data_o = r_tgt[7:0];
      8'h03: b_data_o = r_step;
      8'h04: b_data_o = 8'(r_intv[INTERVAL_BITS-1:8]);
      8'h05: b_data_o = r_intv[7:0];
      8'h06: b_data_o = {5'b0, r_aborted, r_done, w_busy};
      8'h07: b_data_o = 8'(r_cur[PWM_BITS-1:8]);
      8'h08: b_data_o = r_cur[7:0];
      default: b_data_o = 8'h00;
    endcase
  end

endmodule
